// File: rtl/vx_dcache_pending_limiter.sv
// Per-lane read limiter between core dcache ports and memory: caps outstanding reads, drain handshake.
// Latency: zero-cycle pass-through on request and response paths; state updates on the next edge.
// Backpressure: reads stall at MAX_PENDING, everything stalls while draining. Perf: VX_PENDING_LIMITER_PERF_EN.
module vx_dcache_pending_limiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    parameter int CTR_BITS    = 44,
    localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    core_req_valid,
    output logic                    core_req_ready,
    input  logic                    core_req_rw,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,

    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,

    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,

    output logic                    core_rsp_valid,
    input  logic                    core_rsp_ready,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,

    input  logic                    drain_req,
    output logic                    drain_ack,
    output logic [CNT_W-1:0]        pending,
    output logic                    underflow_err,
    output logic [CTR_BITS-1:0]     perf_loads,
    output logic [CTR_BITS-1:0]     perf_load_lat,
    output logic [CNT_W-1:0]        perf_max_pending
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAINING,
        S_DRAINED
    } drain_state_t;

    drain_state_t     state_q;
    logic             drain_ack_q;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             underflow_q, underflow_d;
    logic             block;
    logic             rd_fire;
    logic             rsp_fire;

    // Ceiling is judged on the registered count only; a same-cycle response does not free a slot.
    assign block          = drain_req | (~core_req_rw & (pending_q == MAX_CNT));
    assign mem_req_valid  = core_req_valid & ~block;
    assign core_req_ready = mem_req_ready & ~block;
    assign mem_req_rw     = core_req_rw;
    assign mem_req_addr   = core_req_addr;
    assign mem_req_data   = core_req_data;
    assign mem_req_byteen = core_req_byteen;
    assign mem_req_tag    = core_req_tag;

    assign core_rsp_valid = mem_rsp_valid;
    assign mem_rsp_ready  = core_rsp_ready;
    assign core_rsp_data  = mem_rsp_data;
    assign core_rsp_tag   = mem_rsp_tag;

    assign rd_fire  = mem_req_valid & mem_req_ready & ~core_req_rw;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    always_comb begin
        pending_d   = pending_q;
        underflow_d = underflow_q;
        if (rd_fire && !rsp_fire) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (rsp_fire && !rd_fire) begin
            if (pending_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                pending_d = pending_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            underflow_q <= underflow_d;
        end
    end

    // Dropping drain_req returns to IDLE from any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            drain_ack_q <= 1'b0;
        end else if (!drain_req) begin
            state_q     <= S_IDLE;
            drain_ack_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_DRAINING;
                    drain_ack_q <= 1'b0;
                end
                S_DRAINING: begin
                    if (pending_q == '0) begin
                        state_q     <= S_DRAINED;
                        drain_ack_q <= 1'b1;
                    end
                end
                S_DRAINED: begin
                    drain_ack_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    drain_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign drain_ack     = drain_ack_q;
    assign pending       = pending_q;
    assign underflow_err = underflow_q;

`ifdef VX_PENDING_LIMITER_PERF_EN
    logic [CTR_BITS-1:0] loads_q;
    logic [CTR_BITS-1:0] load_lat_q;
    logic [CNT_W-1:0]    max_pending_q;

    // Latency integrates the outstanding count per cycle, so total/loads gives average load latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loads_q       <= '0;
            load_lat_q    <= '0;
            max_pending_q <= '0;
        end else begin
            loads_q    <= loads_q + CTR_BITS'(rd_fire);
            load_lat_q <= load_lat_q + CTR_BITS'(pending_q);
            if (pending_d > max_pending_q) begin
                max_pending_q <= pending_d;
            end
        end
    end

    assign perf_loads       = loads_q;
    assign perf_load_lat    = load_lat_q;
    assign perf_max_pending = max_pending_q;
`else
    assign perf_loads       = '0;
    assign perf_load_lat    = '0;
    assign perf_max_pending = '0;
`endif

endmodule

// File: tb/tb_vx_dcache_pending_limiter.sv
// Testbench for vx_dcache_pending_limiter (MAX_PENDING=4): directed table, drain/reset/perf sequences,
// then randomized traffic against a count-based reference model.
module tb_vx_dcache_pending_limiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TW   = 8;
    localparam int MAXP = 4;
    localparam int CB   = 44;
    localparam int CW   = $clog2(MAXP + 1);
`ifdef VX_PENDING_LIMITER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            core_req_valid, core_req_ready, core_req_rw;
    logic [AW-1:0]   core_req_addr;
    logic [DW-1:0]   core_req_data;
    logic [DW/8-1:0] core_req_byteen;
    logic [TW-1:0]   core_req_tag;
    logic            mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_data;
    logic [DW/8-1:0] mem_req_byteen;
    logic [TW-1:0]   mem_req_tag;
    logic            mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0]   mem_rsp_data;
    logic [TW-1:0]   mem_rsp_tag;
    logic            core_rsp_valid, core_rsp_ready;
    logic [DW-1:0]   core_rsp_data;
    logic [TW-1:0]   core_rsp_tag;
    logic            drain_req, drain_ack, underflow_err;
    logic [CW-1:0]   pending, perf_max_pending;
    logic [CB-1:0]   perf_loads, perf_load_lat;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vx_dcache_pending_limiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_PENDING(MAXP), .CTR_BITS(CB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_rw(core_req_rw),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data),
        .core_req_byteen(core_req_byteen), .core_req_tag(core_req_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
        .drain_req(drain_req), .drain_ack(drain_ack), .pending(pending),
        .underflow_err(underflow_err), .perf_loads(perf_loads),
        .perf_load_lat(perf_load_lat), .perf_max_pending(perf_max_pending)
    );

    typedef struct {
        bit rw, v, mr, rv, rr, dr;
        bit exp_mv, exp_cr;
        int exp_pend;
        bit exp_err, exp_ack;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit rw, input bit v, input bit mr, input bit rv, input bit rr, input bit dr);
        core_req_rw    = rw;
        core_req_valid = v;
        mem_req_ready  = mr;
        mem_rsp_valid  = rv;
        core_rsp_ready = rr;
        drain_req      = dr;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    function automatic vec_t mk(bit rw, bit v, bit mr, bit rv, bit rr, bit dr,
                                bit mv, bit cr, int p, bit e, bit a);
        vec_t t;
        t.rw = rw; t.v = v; t.mr = mr; t.rv = rv; t.rr = rr; t.dr = dr;
        t.exp_mv = mv; t.exp_cr = cr; t.exp_pend = p; t.exp_err = e; t.exp_ack = a;
        return t;
    endfunction

    // Reference model state: a plain outstanding-read count plus drain bookkeeping.
    int      m_pend;
    bit      m_err, m_ack, m_dprev;
    longint  m_loads, m_lat, m_max;
    localparam longint CMASK = (64'd1 << CB) - 1;

    initial begin
        core_req_addr = '0; core_req_data = '0; core_req_byteen = '0; core_req_tag = '0;
        mem_rsp_data = '0; mem_rsp_tag = '0;
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk("reset_pending", 64'(pending), 0);
        chk("reset_ack", 64'(drain_ack), 0);
        chk("reset_err", 64'(underflow_err), 0);
        chk("reset_perf_loads", 64'(perf_loads), 0);
        chk("reset_perf_lat", 64'(perf_load_lat), 0);
        chk("reset_perf_max", 64'(perf_max_pending), 0);
        do_reset();

        // ceiling, write bypass, blocked read during response, overlap, underflow
        tbl.push_back(mk(0,1,1,0,1,0, 1,1,0,0,0));
        tbl.push_back(mk(0,1,1,0,1,0, 1,1,1,0,0));
        tbl.push_back(mk(0,1,1,0,1,0, 1,1,2,0,0));
        tbl.push_back(mk(0,1,1,0,1,0, 1,1,3,0,0));
        tbl.push_back(mk(0,1,1,0,1,0, 0,0,4,0,0));
        tbl.push_back(mk(1,1,1,0,1,0, 1,1,4,0,0));
        tbl.push_back(mk(0,1,1,1,1,0, 0,0,4,0,0));
        tbl.push_back(mk(0,1,1,0,1,0, 1,1,3,0,0));
        tbl.push_back(mk(1,0,1,0,1,0, 0,1,4,0,0));
        tbl.push_back(mk(1,0,1,1,1,0, 0,1,4,0,0));
        tbl.push_back(mk(1,0,1,1,1,0, 0,1,3,0,0));
        tbl.push_back(mk(0,1,1,1,1,0, 1,1,2,0,0));
        tbl.push_back(mk(1,0,1,0,1,0, 0,1,2,0,0));
        tbl.push_back(mk(1,0,1,1,1,0, 0,1,2,0,0));
        tbl.push_back(mk(1,0,1,1,1,0, 0,1,1,0,0));
        tbl.push_back(mk(1,0,1,0,1,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,1,1,1,0, 0,1,0,0,0));
        tbl.push_back(mk(1,0,1,0,1,0, 0,1,0,1,0));
        tbl.push_back(mk(0,0,1,0,1,0, 0,1,0,1,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rw, tbl[i].v, tbl[i].mr, tbl[i].rv, tbl[i].rr, tbl[i].dr);
            #1;
            chk($sformatf("tbl%0d_mem_req_valid", i), 64'(mem_req_valid), 64'(tbl[i].exp_mv));
            chk($sformatf("tbl%0d_core_req_ready", i), 64'(core_req_ready), 64'(tbl[i].exp_cr));
            chk($sformatf("tbl%0d_pending", i), 64'(pending), 64'(tbl[i].exp_pend));
            chk($sformatf("tbl%0d_underflow", i), 64'(underflow_err), 64'(tbl[i].exp_err));
            chk($sformatf("tbl%0d_ack", i), 64'(drain_ack), 64'(tbl[i].exp_ack));
            tick();
        end

        // async reset mid-stream clears count and sticky error without waiting for an edge
        drive(0, 1, 1, 0, 1, 0);
        tick();
        tick();
        chk("pre_reset_pending", 64'(pending), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pending", 64'(pending), 0);
        chk("async_reset_err", 64'(underflow_err), 0);
        chk("async_reset_ack", 64'(drain_ack), 0);
        do_reset();

        // drain with three reads outstanding
        drive(0, 1, 1, 0, 1, 0);
        tick(); tick(); tick();
        drive(0, 1, 1, 0, 1, 1);
        #1;
        chk("drain_read_blocked_v", 64'(mem_req_valid), 0);
        chk("drain_read_blocked_r", 64'(core_req_ready), 0);
        drive(1, 1, 1, 0, 1, 1);
        #1;
        chk("drain_write_blocked_v", 64'(mem_req_valid), 0);
        chk("drain_write_blocked_r", 64'(core_req_ready), 0);
        tick();
        drive(1, 1, 1, 1, 1, 1);
        tick(); tick(); tick();
        drive(1, 0, 1, 0, 1, 1);
        chk("drain_pending_zero", 64'(pending), 0);
        chk("drain_ack_not_yet", 64'(drain_ack), 0);
        tick();
        chk("drain_ack_set", 64'(drain_ack), 1);
        tick();
        chk("drain_ack_held", 64'(drain_ack), 1);
        drive(1, 0, 1, 0, 1, 0);
        tick();
        chk("drain_ack_drop", 64'(drain_ack), 0);

        // drain raised while already idle: ack two edges later
        drive(1, 0, 1, 0, 1, 1);
        tick();
        chk("drain_idle_ack_1", 64'(drain_ack), 0);
        tick();
        chk("drain_idle_ack_2", 64'(drain_ack), 1);
        drive(1, 0, 1, 0, 1, 0);
        tick();

        // perf: two non-overlapping reads, each returned three cycles after issue
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 0, 1, 0);
            tick();
            drive(1, 0, 1, 0, 1, 0);
            tick(); tick();
            drive(1, 0, 1, 1, 1, 0);
            tick();
        end
        drive(1, 0, 1, 0, 1, 0);
        chk("perf_loads", 64'(perf_loads), PERF ? 64'd2 : 64'd0);
        chk("perf_load_lat", 64'(perf_load_lat), PERF ? 64'd6 : 64'd0);
        chk("perf_max_pending", 64'(perf_max_pending), PERF ? 64'd1 : 64'd0);

        // randomized traffic against the reference model
        do_reset();
        m_pend = 0; m_err = 0; m_ack = 0; m_dprev = 0;
        m_loads = 0; m_lat = 0; m_max = 0;
        for (int c = 0; c < 3000; c++) begin
            bit rw, v, mr, rv, rr, dr, blk, e_mv, e_cr, rd, rsp;
            dr = drain_req;
            if ($urandom_range(0, 39) == 0) dr = ~dr;
            rw = ($urandom_range(0, 3) == 0);
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 4) != 0);
            rv = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            rr = ($urandom_range(0, 4) != 0);
            drive(rw, v, mr, rv, rr, dr);
            core_req_addr = $urandom;
            mem_rsp_tag   = TW'($urandom);
            #1;
            blk  = dr || (!rw && m_pend == MAXP);
            e_mv = v && !blk;
            e_cr = mr && !blk;
            rd   = e_mv && mr && !rw;
            rsp  = rv && rr;
            chk($sformatf("rnd%0d_mem_req_valid", c), 64'(mem_req_valid), 64'(e_mv));
            chk($sformatf("rnd%0d_core_req_ready", c), 64'(core_req_ready), 64'(e_cr));
            chk($sformatf("rnd%0d_pending", c), 64'(pending), 64'(m_pend));
            chk($sformatf("rnd%0d_ack", c), 64'(drain_ack), 64'(m_ack));
            chk($sformatf("rnd%0d_underflow", c), 64'(underflow_err), 64'(m_err));
            chk($sformatf("rnd%0d_addr", c), 64'(mem_req_addr), 64'(core_req_addr));
            chk($sformatf("rnd%0d_rsp_tag", c), 64'(core_rsp_tag), 64'(mem_rsp_tag));
            chk($sformatf("rnd%0d_rsp_ready", c), 64'(mem_rsp_ready), 64'(rr));
            chk($sformatf("rnd%0d_perf_loads", c), 64'(perf_loads), PERF ? 64'(m_loads) : 64'd0);
            chk($sformatf("rnd%0d_perf_lat", c), 64'(perf_load_lat), PERF ? 64'(m_lat) : 64'd0);
            chk($sformatf("rnd%0d_perf_max", c), 64'(perf_max_pending), PERF ? 64'(m_max) : 64'd0);
            m_ack   = dr && (m_ack || (m_dprev && m_pend == 0));
            m_dprev = dr;
            m_lat   = (m_lat + m_pend) & CMASK;
            if (rd) m_loads = (m_loads + 1) & CMASK;
            if (rd && !rsp) m_pend++;
            else if (rsp && !rd) begin
                if (m_pend == 0) m_err = 1;
                else m_pend--;
            end
            if (m_pend > m_max) m_max = m_pend;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
